// File: rtl/rv32i_types.sv
// Shared types and line geometry for the memory arbiter and its read-beat collector.
package rv32i_types;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    RESP     = 3'd4
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } arb_port_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Collects 64-bit read beats into a 256-bit line buffer, one slot per beat index.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat_we,
  input  logic [CNT_W-1:0]     beat_idx,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic [LINE_BITS-1:0] line
);

  logic [BURST_LEN-1:0][BEAT_BITS-1:0] line_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_buf <= '0;
    end else if (beat_we) begin
      line_buf[beat_idx] <= beat_data;
    end
  end

  assign line = line_buf;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto a single burst memory port,
// one transaction outstanding at a time, round-robin on ties.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [31:0]          i_dfp_addr,
  input  logic                 i_dfp_read,
  output logic [LINE_BITS-1:0] i_dfp_rdata,
  output logic                 i_dfp_resp,

  input  logic [31:0]          d_dfp_addr,
  input  logic                 d_dfp_read,
  input  logic                 d_dfp_write,
  input  logic [LINE_BITS-1:0] d_dfp_wdata,
  output logic [LINE_BITS-1:0] d_dfp_rdata,
  output logic                 d_dfp_resp,

  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,

  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int              CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [31:0]     LINE_MASK = ~32'h1f;

  arb_state_t                          state;
  arb_port_t                           last_grant;
  logic [CNT_W-1:0]                    beat_cnt;
  logic [31:0]                         addr_q;
  logic [BURST_LEN-1:0][BEAT_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0]                line;

  logic i_pend, d_pend, any_pend, grant_d, grant_wr;
  logic beat_hit, wr_accept, last_beat;

  assign i_pend   = i_dfp_read;
  assign d_pend   = d_dfp_read | d_dfp_write;
  assign any_pend = i_pend | d_pend;
  // D wins when alone, or on a tie when I was granted last.
  assign grant_d  = d_pend & (~i_pend | (last_grant == PORT_I));
  assign grant_wr = grant_d & d_dfp_write;

  assign beat_hit  = (state == RD_WAIT) & bmem_rvalid & (bmem_raddr == addr_q);
  assign wr_accept = (state == WR_BURST) & bmem_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_grant <= PORT_I;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            last_grant <= grant_d ? PORT_D : PORT_I;
            beat_cnt   <= '0;
            state      <= grant_wr ? WR_BURST : RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) state <= RD_WAIT;
        end
        RD_WAIT, WR_BURST: begin
          if (beat_hit | wr_accept) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Request payload is captured at grant; the requester holds it anyway until resp.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && any_pend) begin
      addr_q  <= (grant_d ? d_dfp_addr : i_dfp_addr) & LINE_MASK;
      wdata_q <= d_dfp_wdata;
    end
  end

  cacheline_adapter #(
    .BURST_LEN (BURST_LEN),
    .CNT_W     (CNT_W)
  ) u_adapter (
    .clk       (clk),
    .rst       (rst),
    .beat_we   (beat_hit),
    .beat_idx  (beat_cnt),
    .beat_data (bmem_rdata),
    .line      (line)
  );

  always_comb begin
    bmem_read  = (state == RD_REQ);
    bmem_write = (state == WR_BURST);
    bmem_addr  = (bmem_read | bmem_write) ? addr_q : '0;
    bmem_wdata = bmem_write ? wdata_q[beat_cnt] : '0;
    i_dfp_resp = (state == RESP) & (last_grant == PORT_I);
    d_dfp_resp = (state == RESP) & (last_grant == PORT_D);
  end

  assign i_dfp_rdata = line;
  assign d_dfp_rdata = line;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, arbitration, address filtering and reset.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_dfp_addr;
  logic         i_dfp_read;
  logic [255:0] i_dfp_rdata;
  logic         i_dfp_resp;
  logic [31:0]  d_dfp_addr;
  logic         d_dfp_read;
  logic         d_dfp_write;
  logic [255:0] d_dfp_wdata;
  logic [255:0] d_dfp_rdata;
  logic         d_dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.BURST_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_dfp_addr  (i_dfp_addr),
    .i_dfp_read  (i_dfp_read),
    .i_dfp_rdata (i_dfp_rdata),
    .i_dfp_resp  (i_dfp_resp),
    .d_dfp_addr  (d_dfp_addr),
    .d_dfp_read  (d_dfp_read),
    .d_dfp_write (d_dfp_write),
    .d_dfp_wdata (d_dfp_wdata),
    .d_dfp_rdata (d_dfp_rdata),
    .d_dfp_resp  (d_dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_beat(input logic [31:0] addr, input logic [63:0] data);
    bmem_rvalid = 1'b1;
    bmem_raddr  = addr;
    bmem_rdata  = data;
    step();
    bmem_rvalid = 1'b0;
  endtask

  logic [63:0]  bt [4];
  logic [63:0]  bu [4];
  logic [255:0] w_line;
  logic         rp [6];
  logic         exp_d;
  logic [31:0]  ea;
  int           acc;
  int           wt;

  initial begin
    bt[0] = 64'haaaa_0000_0000_000a; bt[1] = 64'hbbbb_0000_0000_000b;
    bt[2] = 64'hcccc_0000_0000_000c; bt[3] = 64'hdddd_0000_0000_000d;
    bu[0] = 64'h1010_2020_3030_4040; bu[1] = 64'h5050_6060_7070_8080;
    bu[2] = 64'h9090_a0a0_b0b0_c0c0; bu[3] = 64'hd0d0_e0e0_f0f0_0101;
    w_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    rp[0] = 1'b1; rp[1] = 1'b0; rp[2] = 1'b1; rp[3] = 1'b1; rp[4] = 1'b0; rp[5] = 1'b1;

    rst = 1'b0;
    i_dfp_addr = '0; i_dfp_read = 1'b0;
    d_dfp_addr = '0; d_dfp_read = 1'b0; d_dfp_write = 1'b0; d_dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    step(); step();
    chk("rst_bmem_read", bmem_read, 1'b0);
    chk("rst_bmem_write", bmem_write, 1'b0);
    chk("rst_bmem_addr", bmem_addr, 32'h0);
    chk("rst_iresp", i_dfp_resp, 1'b0);
    chk("rst_dresp", d_dfp_resp, 1'b0);
    chk("rst_irdata", i_dfp_rdata, 256'h0);
    rst = 1'b1;
    step();

    // I read of 0x1eceb004, ready high, resp expected six edges after request
    i_dfp_addr = 32'h1eceb004; i_dfp_read = 1'b1; bmem_ready = 1'b1;
    step();
    chk("t1_bmem_read", bmem_read, 1'b1);
    chk("t1_bmem_addr", bmem_addr, 32'h1eceb000);
    step();
    chk("t1_read_dropped", bmem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      feed_beat(32'h1eceb000, bt[k]);
      chk("t1_iresp", i_dfp_resp, (k == 3));
    end
    chk("t1_irdata", i_dfp_rdata, {bt[3], bt[2], bt[1], bt[0]});
    chk("t1_dresp", d_dfp_resp, 1'b0);
    i_dfp_read = 1'b0;
    step();
    chk("t1_iresp_single", i_dfp_resp, 1'b0);

    // Simultaneous I and D reads right after reset: D first, then I
    rst = 1'b0; step(); rst = 1'b1; step();
    i_dfp_addr = 32'h0000_0100; i_dfp_read = 1'b1;
    d_dfp_addr = 32'h0000_2044; d_dfp_read = 1'b1;
    step();
    chk("t2_d_first_read", bmem_read, 1'b1);
    chk("t2_d_first_addr", bmem_addr, 32'h0000_2040);
    step();
    for (int k = 0; k < 4; k++) feed_beat(32'h0000_2040, bu[k]);
    chk("t2_dresp", d_dfp_resp, 1'b1);
    chk("t2_iresp_idle", i_dfp_resp, 1'b0);
    chk("t2_drdata", d_dfp_rdata, {bu[3], bu[2], bu[1], bu[0]});
    chk("t2_no_overlap_resp", bmem_read, 1'b0);
    d_dfp_read = 1'b0;
    step();
    chk("t2_no_overlap_idle", bmem_read, 1'b0);
    step();
    chk("t2_i_second_read", bmem_read, 1'b1);
    chk("t2_i_second_addr", bmem_addr, 32'h0000_0100);
    step();
    for (int k = 0; k < 4; k++) feed_beat(32'h0000_0100, bt[k]);
    chk("t2_iresp", i_dfp_resp, 1'b1);
    chk("t2_irdata", i_dfp_rdata, {bt[3], bt[2], bt[1], bt[0]});
    i_dfp_read = 1'b0;
    step();

    // D write with a stalling memory; read+write together counts as write
    d_dfp_addr = 32'h8000_0020; d_dfp_wdata = w_line;
    d_dfp_write = 1'b1; d_dfp_read = 1'b1; bmem_ready = 1'b0;
    step();
    acc = 0;
    for (int j = 0; j < 6; j++) begin
      bmem_ready = rp[j];
      chk("t3_bmem_write", bmem_write, 1'b1);
      chk("t3_bmem_read", bmem_read, 1'b0);
      chk("t3_bmem_addr", bmem_addr, 32'h8000_0020);
      chk("t3_bmem_wdata", bmem_wdata, w_line[64*acc +: 64]);
      chk("t3_dresp_early", d_dfp_resp, 1'b0);
      if (bmem_write && bmem_ready) acc++;
      step();
    end
    chk("t3_dresp", d_dfp_resp, 1'b1);
    chk("t3_write_done", bmem_write, 1'b0);
    d_dfp_write = 1'b0; d_dfp_read = 1'b0; bmem_ready = 1'b1;
    step();
    chk("t3_dresp_single", d_dfp_resp, 1'b0);

    // Mismatched beat address ignored; RD_REQ holds while ready is low
    i_dfp_addr = 32'h1eceb000; i_dfp_read = 1'b1; bmem_ready = 1'b0;
    step(); step();
    chk("t4_rdreq_hold", bmem_read, 1'b1);
    bmem_ready = 1'b1;
    step();
    feed_beat(32'h1eceb000, bu[0]);
    feed_beat(32'h0000_0000, 64'hdead_beef_dead_beef);
    chk("t4_bad_beat_no_resp", i_dfp_resp, 1'b0);
    feed_beat(32'h1eceb000, bu[1]);
    feed_beat(32'h1eceb000, bu[2]);
    chk("t4_cnt_unchanged", i_dfp_resp, 1'b0);
    feed_beat(32'h1eceb000, bu[3]);
    chk("t4_iresp", i_dfp_resp, 1'b1);
    chk("t4_irdata", i_dfp_rdata, {bu[3], bu[2], bu[1], bu[0]});
    i_dfp_read = 1'b0;
    step();

    // Reset after two read beats: transaction abandoned, late beats discarded
    i_dfp_addr = 32'h0000_0040; i_dfp_read = 1'b1;
    step(); step();
    feed_beat(32'h0000_0040, bt[0]);
    feed_beat(32'h0000_0040, bt[1]);
    rst = 1'b0; i_dfp_read = 1'b0;
    #1;
    chk("t5_rst_bmem_read", bmem_read, 1'b0);
    chk("t5_rst_bmem_addr", bmem_addr, 32'h0);
    chk("t5_rst_irdata", i_dfp_rdata, 256'h0);
    chk("t5_rst_iresp", i_dfp_resp, 1'b0);
    step(); step();
    rst = 1'b1;
    feed_beat(32'h0000_0040, bt[2]);
    chk("t5_late_beat_dropped", i_dfp_rdata, 256'h0);
    chk("t5_no_resp", i_dfp_resp, 1'b0);
    i_dfp_addr = 32'h0000_0060; i_dfp_read = 1'b1;
    step();
    chk("t5_new_addr", bmem_addr, 32'h0000_0060);
    step();
    for (int k = 0; k < 4; k++) feed_beat(32'h0000_0060, bu[k]);
    chk("t5_new_iresp", i_dfp_resp, 1'b1);
    chk("t5_new_irdata", i_dfp_rdata, {bu[3], bu[2], bu[1], bu[0]});
    i_dfp_read = 1'b0;
    step();

    // Continuous I and D reads: grants must alternate, D first
    i_dfp_addr = 32'h0000_1000; d_dfp_addr = 32'h0000_2000;
    i_dfp_read = 1'b1; d_dfp_read = 1'b1; bmem_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      exp_d = (t % 2 == 0);
      ea = exp_d ? 32'h0000_2000 : 32'h0000_1000;
      wt = 0;
      while (!bmem_read && wt < 6) begin
        step();
        wt++;
      end
      chk("t6_grant_seen", bmem_read, 1'b1);
      chk("t6_grant_addr", bmem_addr, ea);
      step();
      for (int k = 0; k < 4; k++) feed_beat(ea, {t, k});
      chk("t6_dresp", d_dfp_resp, exp_d);
      chk("t6_iresp", i_dfp_resp, !exp_d);
    end
    i_dfp_read = 1'b0; d_dfp_read = 1'b0;
    step();
    chk("t6_idle_read", bmem_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, meaning the number of 64-bit beats per 256-bit cache line.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports i_dfp_addr (input, 32), i_dfp_read (input, 1), i_dfp_rdata (output, 256) and i_dfp_resp (output, 1), forming the I-cache read-only line port.
REQ-005 SHALL have ports d_dfp_addr (input, 32), d_dfp_read (input, 1), d_dfp_write (input, 1), d_dfp_wdata (input, 256), d_dfp_rdata (output, 256) and d_dfp_resp (output, 1), forming the D-cache line port.
REQ-006 SHALL have ports bmem_addr (output, 32), bmem_read (output, 1), bmem_write (output, 1), bmem_wdata (output, 64) and bmem_ready (input, 1), forming the memory request side.
REQ-007 SHALL have ports bmem_raddr (input, 32), bmem_rdata (input, 64) and bmem_rvalid (input, 1), forming the memory return side.

Function
REQ-010 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_BURST and RESP.
REQ-011 SHALL allow at most one bmem transaction outstanding at any time.
REQ-012 SHALL, in IDLE, grant to a pending requester, where pending means read or write is high; both pending resolves round-robin, favouring the port not granted last; last_grant resets to I so that D wins the first tie.
REQ-013 SHALL, on grant, latch the port, line address {addr[31:5],5'b0}, operation and wdata; requesters hold their request until resp.
REQ-014 SHALL treat a D port asserting read and write together as a write.
REQ-015 SHALL, in RD_REQ, drive bmem_read=1 and bmem_addr=latched address, and move to RD_WAIT on the cycle bmem_ready=1; while bmem_ready=0 it stays in RD_REQ.
REQ-016 SHALL, in RD_WAIT, shift each bmem_rdata with bmem_rvalid=1 and bmem_raddr==latched address into line slot beat_cnt, 63:0 first, ignoring mismatched beats; after BURST_LEN beats it moves to RESP.
REQ-017 SHALL, in WR_BURST, drive bmem_write=1, bmem_addr=latched address and bmem_wdata=wdata[64*beat_cnt +: 64]; beat_cnt advances only when bmem_ready=1, and after BURST_LEN accepted beats it moves to RESP.
REQ-018 SHALL, in RESP, pulse the granted port's resp for exactly 1 cycle, with rdata valid the same cycle for reads (write rdata is don't-care), then return to IDLE; a new grant is possible the following cycle.
REQ-019 SHALL keep bmem_read, bmem_write and both resp signals 0 outside their respective states.
REQ-020 SHALL make beat_cnt $clog2(BURST_LEN) bits wide, cleared on every grant; it wraps to 0 on the final beat.
REQ-021 SHALL have a minimum read latency of 1 (RD_REQ) + BURST_LEN beats + 1 (RESP) cycles from grant, and a minimum write latency of BURST_LEN + 1 cycles.
REQ-022 SHALL ignore a request that drops without a resp (illegal); an already granted transaction still completes.

Reset
REQ-030 SHALL, while rst=0, force state=IDLE, beat_cnt=0, last_grant=I and the line buffer to 0, with all outputs 0.
REQ-031 SHALL, on reset mid-burst, abandon the transaction with no resp issued; late bmem_rvalid beats in IDLE are discarded.

Structure
REQ-040 SHALL place the arb_state_t enum and the LINE_BITS=256 and BEAT_BITS=64 constants in rv32i_types.
REQ-041 SHALL reuse the existing cacheline_adapter as its one sub-module for read-beat collection, and SHALL otherwise be flat.

Verification
REQ-050 SHALL verify an I read of 0x1eceb004 with ready=1, beats A,B,C,D: bmem_addr=0x1eceb000, i_dfp_rdata={D,C,B,A}, i_dfp_resp pulse at cycle 6.
REQ-051 SHALL verify simultaneous I read and D read after reset: D served first, then I, with no overlap on bmem_read.
REQ-052 SHALL verify a D write of 0x80000020 with wdata=W and bmem_ready toggling 1,0,1,1,0,1: exactly 4 write beats W[63:0]..W[255:192] and d_dfp_resp after the 4th accepted beat.
REQ-053 SHALL verify a beat with bmem_raddr=0x0 during RD_WAIT for 0x1eceb000: the beat is ignored and beat_cnt is unchanged.
REQ-054 SHALL verify rst=0 asserted after 2 read beats: outputs 0, no resp, and a next read completes correctly.
REQ-055 SHALL verify continuous I and D requests for 20 transactions: grants alternate I/D strictly.
